// File: rtl/sequenciador_display_usuario.sv
// User-session sequencer feeding the 7-segment decoder's User[2:0] input.
// Optional macro PILOTO_AUTOMATICO_EN: when defined, code 111 (autopilot) is a valid session code.
module sequenciador_display_usuario #(
    parameter int TIMEOUT     = 1000,
    parameter int BLINK_HALF  = 25,
    parameter int ERR_CYCLES  = 200,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] codigo_in,
    input  logic       confirmar,
    output logic [2:0] disp_code,
    output logic       sessao_ativa,
    output logic       bloqueado,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACTIVE  = 2'b01,
        S_INVALID = 2'b10,
        S_LOCKED  = 2'b11
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] BLINK_LAST   = 16'(BLINK_HALF - 1);
    localparam logic [15:0] ERR_LAST     = 16'(ERR_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] FAIL_LIMIT   = 16'(MAX_FAIL);
    localparam logic [2:0]  LOCK_DISPLAY = 3'b010;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_cnt;
    logic [15:0] w_nextCnt;
    logic [15:0] r_blinkCnt;
    logic [15:0] w_nextBlinkCnt;
    logic        r_blinkOdd;
    logic        w_nextBlinkOdd;
    logic [15:0] r_failCnt;
    logic [15:0] w_nextFailCnt;
    logic [15:0] w_failInc;
    logic [2:0]  r_code;
    logic [2:0]  w_nextCode;
    logic        r_confPrev;
    logic        w_confEvent;
    logic        w_codeValid;
    logic        w_codeNeutral;
    logic [2:0]  r_dispCode;
    logic [2:0]  w_nextDisp;
    logic        r_sessao;
    logic        r_bloqueado;
    logic [1:0]  r_estado;

    function automatic logic isValidCode(input logic [2:0] code);
        logic valid;
        case (code)
            3'b001, 3'b011, 3'b101, 3'b110: valid = 1'b1;
`ifdef PILOTO_AUTOMATICO_EN
            3'b111:                         valid = 1'b1;
`else
            3'b111:                         valid = 1'b0;
`endif
            default:                        valid = 1'b0;
        endcase
        return valid;
    endfunction

    assign w_confEvent   = confirmar & ~r_confPrev;
    assign w_codeValid   = isValidCode(codigo_in);
    assign w_codeNeutral = (codigo_in == 3'b000);
    assign w_failInc     = r_failCnt + 16'd1;

    // One shared counter serves as inactivity timer, INVALID phase or lock timer,
    // since only one of them is live in any given state.
    always_comb begin
        w_nextState    = r_state;
        w_nextCnt      = r_cnt;
        w_nextBlinkCnt = r_blinkCnt;
        w_nextBlinkOdd = r_blinkOdd;
        w_nextFailCnt  = r_failCnt;
        w_nextCode     = r_code;
        case (r_state)
            S_IDLE: begin
                if (w_confEvent) begin
                    if (w_codeValid) begin
                        w_nextCode    = codigo_in;
                        w_nextFailCnt = 16'd0;
                        w_nextCnt     = 16'd0;
                        w_nextState   = S_ACTIVE;
                    end else if (!w_codeNeutral) begin
                        w_nextFailCnt  = w_failInc;
                        w_nextCnt      = 16'd0;
                        w_nextBlinkCnt = 16'd0;
                        w_nextBlinkOdd = 1'b0;
                        if (w_failInc == FAIL_LIMIT) begin
                            w_nextState = S_LOCKED;
                        end else begin
                            w_nextState = S_INVALID;
                            w_nextCode  = codigo_in;
                        end
                    end
                end
            end
            S_ACTIVE: begin
                if (w_confEvent) begin
                    w_nextCnt = 16'd0;
                    if (w_codeValid) begin
                        w_nextCode = codigo_in;
                    end else if (w_codeNeutral) begin
                        w_nextState = S_IDLE;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_nextCnt   = 16'd0;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + 16'd1;
                end
            end
            S_INVALID: begin
                if (r_cnt == ERR_LAST) begin
                    w_nextCnt   = 16'd0;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + 16'd1;
                    if (r_blinkCnt == BLINK_LAST) begin
                        w_nextBlinkCnt = 16'd0;
                        w_nextBlinkOdd = ~r_blinkOdd;
                    end else begin
                        w_nextBlinkCnt = r_blinkCnt + 16'd1;
                    end
                end
            end
            S_LOCKED: begin
                if (r_cnt == LOCK_LAST) begin
                    w_nextCnt     = 16'd0;
                    w_nextFailCnt = 16'd0;
                    w_nextState   = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Display value is decided from the upcoming state so the output registers
    // change on the same edge that samples the confirm event.
    always_comb begin
        w_nextDisp = 3'b000;
        case (w_nextState)
            S_ACTIVE:  w_nextDisp = w_nextCode;
            S_INVALID: w_nextDisp = w_nextBlinkOdd ? 3'b000 : w_nextCode;
            S_LOCKED:  w_nextDisp = LOCK_DISPLAY;
            default:   w_nextDisp = 3'b000;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_blinkCnt  <= 16'd0;
            r_blinkOdd  <= 1'b0;
            r_failCnt   <= 16'd0;
            r_code      <= 3'b000;
            r_confPrev  <= 1'b0;
            r_dispCode  <= 3'b000;
            r_sessao    <= 1'b0;
            r_bloqueado <= 1'b0;
            r_estado    <= 2'b00;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            r_blinkCnt  <= w_nextBlinkCnt;
            r_blinkOdd  <= w_nextBlinkOdd;
            r_failCnt   <= w_nextFailCnt;
            r_code      <= w_nextCode;
            r_confPrev  <= confirmar;
            r_dispCode  <= w_nextDisp;
            r_sessao    <= (w_nextState == S_ACTIVE);
            r_bloqueado <= (w_nextState == S_LOCKED);
            r_estado    <= w_nextState;
        end
    end

    assign disp_code    = r_dispCode;
    assign sessao_ativa = r_sessao;
    assign bloqueado    = r_bloqueado;
    assign estado       = r_estado;

endmodule

// File: tb/tb_sequenciador_display_usuario.sv
// Self-checking bench for sequenciador_display_usuario: directed steps then random confirms,
// all compared against a cycle-age based session model.
module tb_sequenciador_display_usuario;

    localparam int TO = 10;
    localparam int BH = 2;
    localparam int EC = 8;
    localparam int MF = 3;
    localparam int LC = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] codigo_in = 3'b000;
    logic       confirmar = 1'b0;
    logic [2:0] disp_code;
    logic       sessao_ativa;
    logic       bloqueado;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 active, 2 invalid, 3 locked; age counts edges since entry/last confirm.
    int         mState = 0;
    int         mAge   = 0;
    int         mFail  = 0;
    logic [2:0] mCode  = 3'b000;
    bit         mPrev  = 1'b0;

    sequenciador_display_usuario #(
        .TIMEOUT(TO), .BLINK_HALF(BH), .ERR_CYCLES(EC), .MAX_FAIL(MF), .LOCK_CYCLES(LC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .codigo_in(codigo_in),
        .confirmar(confirmar),
        .disp_code(disp_code),
        .sessao_ativa(sessao_ativa),
        .bloqueado(bloqueado),
        .estado(estado)
    );

    always #5 clock = ~clock;

    function automatic bit modelValid(input logic [2:0] c);
`ifdef PILOTO_AUTOMATICO_EN
        return (c == 3'b001) || (c == 3'b011) || (c == 3'b101) || (c == 3'b110) || (c == 3'b111);
`else
        return (c == 3'b001) || (c == 3'b011) || (c == 3'b101) || (c == 3'b110);
`endif
    endfunction

    task automatic modelReset();
        mState = 0;
        mAge   = 0;
        mFail  = 0;
        mCode  = 3'b000;
        mPrev  = 1'b0;
    endtask

    task automatic modelStep(input logic [2:0] code, input bit conf);
        bit ev;
        ev    = conf && !mPrev;
        mPrev = conf;
        case (mState)
            0: if (ev) begin
                if (modelValid(code)) begin
                    mCode = code; mFail = 0; mState = 1; mAge = 0;
                end else if (code != 3'b000) begin
                    mFail++;
                    mAge = 0;
                    if (mFail == MF) mState = 3;
                    else begin mState = 2; mCode = code; end
                end
            end
            1: if (ev) begin
                mAge = 0;
                if (modelValid(code)) mCode = code;
                else if (code == 3'b000) mState = 0;
            end else begin
                mAge++;
                if (mAge == TO) mState = 0;
            end
            2: begin
                mAge++;
                if (mAge == EC) mState = 0;
            end
            default: begin
                mAge++;
                if (mAge == LC) begin mState = 0; mFail = 0; end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        logic [2:0] expDisp;
        case (mState)
            1:       expDisp = mCode;
            2:       expDisp = (((mAge / BH) % 2) == 1) ? 3'b000 : mCode;
            3:       expDisp = 3'b010;
            default: expDisp = 3'b000;
        endcase
        checks++;
        assert (disp_code === expDisp) else begin
            errors++;
            $error("FAIL %s disp_code: observed %b expected %b", tag, disp_code, expDisp);
        end
        checks++;
        assert (estado === 2'(mState)) else begin
            errors++;
            $error("FAIL %s estado: observed %b expected %b", tag, estado, 2'(mState));
        end
        checks++;
        assert (sessao_ativa === (mState == 1)) else begin
            errors++;
            $error("FAIL %s sessao_ativa: observed %b expected %b", tag, sessao_ativa, (mState == 1));
        end
        checks++;
        assert (bloqueado === (mState == 3)) else begin
            errors++;
            $error("FAIL %s bloqueado: observed %b expected %b", tag, bloqueado, (mState == 3));
        end
    endtask

    task automatic applyStimulus(input logic [2:0] code, input bit conf, input string tag);
        codigo_in = code;
        confirmar = conf;
        @(posedge clock);
        if (reset) modelReset();
        else modelStep(code, conf);
        #1;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(3'b000, 1'b0, tag);
    endtask

    task automatic pressCode(input logic [2:0] code, input string tag);
        applyStimulus(code, 1'b1, tag);
        applyStimulus(3'b000, 1'b0, tag);
    endtask

    task automatic asyncResetCheck(input string tag);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        applyStimulus(3'b000, 1'b0, tag);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        checkOutput("reset_async_start");
        applyStimulus(3'b000, 1'b0, "reset_held");
        reset = 1'b0;
        idleCycles(2, "idle");

        // Login, user switch, then inactivity timeout.
        pressCode(3'b001, "login_001");
        pressCode(3'b101, "switch_101");
        idleCycles(TO + 2, "timeout");

        // Confirm on the very edge the timeout would fire keeps the session.
        applyStimulus(3'b101, 1'b1, "login_101");
        for (int i = 0; i < TO - 1; i++) applyStimulus(3'b000, 1'b0, "pre_timeout");
        applyStimulus(3'b101, 1'b1, "confirm_at_timeout");
        applyStimulus(3'b011, 1'b1, "held_high");
        applyStimulus(3'b000, 1'b1, "held_high_zero");
        applyStimulus(3'b011, 1'b0, "release");
        pressCode(3'b011, "relatch_011");
        pressCode(3'b100, "active_invalid_ignored");
        pressCode(3'b000, "logout");
        pressCode(3'b000, "idle_neutral");

        // Blink, second fail, then lockout on the third.
        pressCode(3'b010, "invalid_010");
        idleCycles(EC, "blink");
        pressCode(3'b100, "invalid_100");
        idleCycles(EC + 1, "blink2");
        pressCode(3'b010, "third_fail_lock");
        idleCycles(LC + 2, "locked");
        pressCode(3'b100, "fail_cleared");
        idleCycles(EC + 1, "blink3");

        pressCode(3'b111, "code_111");
        idleCycles(EC + 2, "after_111");
        pressCode(3'b000, "logout_111");

        // Asynchronous reset in the middle of INVALID and of LOCKED.
        pressCode(3'b010, "inv_for_reset");
        idleCycles(2, "mid_invalid");
        asyncResetCheck("reset_mid_invalid");
        for (int k = 0; k < MF; k++) begin
            pressCode(3'b100, "to_lock");
            idleCycles(EC, "to_lock_wait");
        end
        idleCycles(3, "mid_locked");
        asyncResetCheck("reset_mid_locked");

        // Confirm already high when reset releases counts as an edge.
        reset = 1'b1;
        applyStimulus(3'b001, 1'b1, "reset_conf_high");
        reset = 1'b0;
        applyStimulus(3'b001, 1'b1, "first_edge_after_reset");
        applyStimulus(3'b001, 1'b0, "after_release");

        // Random confirms with occasional quiet stretches.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) idleCycles(TO + 1, "rand_quiet");
            applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
